// File: rtl/trap_pkg.sv
// trap_pkg: cause codes and sequencer state encoding shared by the trap logic.
package trap_pkg;
    localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
    localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SAVE,
        HANDLER,
        RESTORE
    } trap_state_t;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: lowest-index-wins priority encoder over active-low interrupt lines.
module trap_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] irq_n,
    output logic         valid,
    output logic [3:0]   idx
);
    always_comb begin
        valid = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!irq_n[i]) begin
                valid = 1'b1;
                idx = 4'(i);
            end
        end
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap arbiter/sequencer driving CSR save/restore strobes.
// TRAP_VECTORED_EN selects vectored interrupt targets; otherwise direct mode.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int NUM_EXT = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EXT-1:0] ext_irq_n,
    input  logic               ti_n,
    input  logic               ecall_n,
    input  logic               ebreak_n,
    input  logic               mret_n,
    input  logic               mstatus_mie,
    input  logic [2:0]         mie_bits,
    input  logic [31:0]        mtvec,
    input  logic               trap_ack,
    output logic               trap_req,
    output logic [31:0]        trap_cause,
    output logic [31:0]        trap_vector,
    output logic [3:0]         ext_id,
    output logic               csr_save_n,
    output logic               csr_restore_n,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_cnt
);
    trap_state_t state, state_nxt;
    logic              ext_v;
    logic [3:0]        ext_idx;
    logic              ecall_e, ebreak_e, tmr_e, ext_e, any_e, take, drop_inc;
    logic [31:0]       best_cause, base, vec_nxt;
    logic [3:0]        best_id;
    logic              unused_mtvec;

    trap_prio_enc #(.N(NUM_EXT)) u_prio (
        .irq_n (ext_irq_n),
        .valid (ext_v),
        .idx   (ext_idx)
    );

    assign ecall_e    = ~ecall_n & mie_bits[0];
    assign ebreak_e   = ~ebreak_n & mie_bits[0];
    assign tmr_e      = ~ti_n & mie_bits[1] & mstatus_mie;
    assign ext_e      = ext_v & mie_bits[2] & mstatus_mie;
    assign any_e      = ecall_e | ebreak_e | tmr_e | ext_e;
    assign best_cause = ecall_e ? CAUSE_ECALL : ebreak_e ? CAUSE_EBREAK : tmr_e ? CAUSE_MTI : CAUSE_MEI;
    assign best_id    = (ecall_e | ebreak_e | tmr_e) ? 4'd0 : ext_idx;
    assign base       = {mtvec[31:2], 2'b00};
    assign unused_mtvec = ^mtvec[1:0];

`ifdef TRAP_VECTORED_EN
    assign vec_nxt = best_cause[31] ? base + {26'd0, best_cause[3:0], 2'b00} : base;
`else
    assign vec_nxt = base;
`endif

    // A latched exception can only be pre-empted by ecall; latched interrupts re-arbitrate each cycle
    always_comb begin
        state_nxt = state;
        take = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = any_e ? REQ : IDLE;
                take = any_e;
            end
            REQ: begin
                if (trap_ack) state_nxt = SAVE;
                else if (!trap_cause[31]) take = ecall_e;
                else if (any_e) take = 1'b1;
                else state_nxt = IDLE;
            end
            SAVE:    state_nxt = HANDLER;
            HANDLER: state_nxt = !mret_n ? RESTORE : HANDLER;
            RESTORE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign drop_inc = (state == HANDLER) & (~ecall_n | ~ebreak_n) & ~&drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            trap_cause  <= '0;
            trap_vector <= '0;
            ext_id      <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            trap_cause  <= take ? best_cause : trap_cause;
            trap_vector <= take ? vec_nxt : trap_vector;
            ext_id      <= take ? best_id : ext_id;
            drop_cnt    <= drop_inc ? drop_cnt + 1'b1 : drop_cnt;
        end
    end

    assign trap_req      = state == REQ;
    assign csr_save_n    = state != SAVE;
    assign csr_restore_n = state != RESTORE;
    assign busy          = (state == HANDLER) | (state == RESTORE);
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized checks of trap_sequencer against a behavioural model.
module tb_trap_sequencer;
    localparam int NUM_EXT = 4;
    localparam int CNT_W   = 8;
`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_EXT-1:0] ext_irq_n = '1;
    logic               ti_n = 1'b1, ecall_n = 1'b1, ebreak_n = 1'b1, mret_n = 1'b1;
    logic               mstatus_mie = 1'b0, trap_ack = 1'b0;
    logic [2:0]         mie_bits = '0;
    logic [31:0]        mtvec = '0;
    logic               trap_req, csr_save_n, csr_restore_n, busy;
    logic [31:0]        trap_cause, trap_vector;
    logic [3:0]         ext_id;
    logic [CNT_W-1:0]   drop_cnt;

    int total = 0;
    int bad = 0;

    // model: which phase of a trap we are in, plus latched trap data
    bit          m_pend, m_save, m_serv, m_rest;
    logic [31:0] m_cause = '0, m_vec = '0;
    logic [3:0]  m_id = '0;
    int          m_drop = 0;

    trap_sequencer #(.NUM_EXT(NUM_EXT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ext_irq_n     (ext_irq_n),
        .ti_n          (ti_n),
        .ecall_n       (ecall_n),
        .ebreak_n      (ebreak_n),
        .mret_n        (mret_n),
        .mstatus_mie   (mstatus_mie),
        .mie_bits      (mie_bits),
        .mtvec         (mtvec),
        .trap_ack      (trap_ack),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .trap_vector   (trap_vector),
        .ext_id        (ext_id),
        .csr_save_n    (csr_save_n),
        .csr_restore_n (csr_restore_n),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vec_of(input logic [31:0] c, input logic [31:0] tv);
        logic [31:0] b;
        b = tv & 32'hFFFF_FFFC;
        return (VEC && c[31]) ? b + 4 * (c & 32'hF) : b;
    endfunction

    task automatic model_edge();
        bit          ec, eb, tm, ex, any;
        int          first;
        logic [31:0] bc;
        logic [3:0]  bi;
        if (!rst_n) begin
            {m_pend, m_save, m_serv, m_rest} = '0;
            m_cause = '0;
            m_vec = '0;
            m_id = '0;
            m_drop = 0;
            return;
        end
        ec = !ecall_n && mie_bits[0];
        eb = !ebreak_n && mie_bits[0];
        tm = !ti_n && mie_bits[1] && mstatus_mie;
        first = -1;
        for (int i = NUM_EXT - 1; i >= 0; i--) if (!ext_irq_n[i]) first = i;
        ex = first >= 0 && mie_bits[2] && mstatus_mie;
        any = ec || eb || tm || ex;
        bi = 4'd0;
        if (ec) bc = 32'hB;
        else if (eb) bc = 32'h3;
        else if (tm) bc = 32'h8000_0007;
        else begin
            bc = 32'h8000_000B;
            bi = 4'(first);
        end
        if (m_serv) begin
            if (!ecall_n || !ebreak_n) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            if (!mret_n) begin
                m_serv = 0;
                m_rest = 1;
            end
        end else if (m_save) begin
            m_save = 0;
            m_serv = 1;
        end else if (m_rest) begin
            m_rest = 0;
        end else if (m_pend) begin
            if (trap_ack) begin
                m_pend = 0;
                m_save = 1;
            end else if (!m_cause[31]) begin
                if (ec) begin
                    m_cause = bc;
                    m_vec = vec_of(bc, mtvec);
                    m_id = bi;
                end
            end else if (any) begin
                m_cause = bc;
                m_vec = vec_of(bc, mtvec);
                m_id = bi;
            end else begin
                m_pend = 0;
            end
        end else if (any) begin
            m_pend = 1;
            m_cause = bc;
            m_vec = vec_of(bc, mtvec);
            m_id = bi;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("trap_req", 32'(trap_req), 32'(m_pend));
        check("save_n", 32'(csr_save_n), 32'(!m_save));
        check("restore_n", 32'(csr_restore_n), 32'(!m_rest));
        check("busy", 32'(busy), 32'(m_serv || m_rest));
        check("cause", trap_cause, m_cause);
        check("vector", trap_vector, m_vec);
        check("ext_id", 32'(ext_id), 32'(m_id));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, 32'(trap_req), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cause"}, trap_cause, 32'd0);
        check({tag, "_vec"}, trap_vector, 32'd0);
        check({tag, "_id"}, 32'(ext_id), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
        check({tag, "_save"}, 32'(csr_save_n), 32'd1);
        check({tag, "_rest"}, 32'(csr_restore_n), 32'd1);
    endtask

    initial begin
        step();
        step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        mstatus_mie = 1'b1;
        mie_bits = 3'b111;
        mtvec = 32'h0000_0101;
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("ack_no_req", 32'(csr_save_n), 32'd1);
        // timer trap, ack, three dropped ebreaks, mret
        ti_n = 1'b0;
        step();
        check("tmr_req", 32'(trap_req), 32'd1);
        check("tmr_cause", trap_cause, 32'h8000_0007);
        check("tmr_vec", trap_vector, VEC ? 32'h11C : 32'h100);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        ti_n = 1'b1;
        check("tmr_save", 32'(csr_save_n), 32'd0);
        step();
        check("tmr_busy", 32'(busy), 32'd1);
        check("tmr_save_end", 32'(csr_save_n), 32'd1);
        repeat (3) begin
            ebreak_n = 1'b0;
            step();
            ebreak_n = 1'b1;
            step();
        end
        check("drop3", 32'(drop_cnt), 32'd3);
        mret_n = 1'b0;
        step();
        mret_n = 1'b1;
        check("mret_rest", 32'(csr_restore_n), 32'd0);
        step();
        check("mret_rest_end", 32'(csr_restore_n), 32'd1);
        check("mret_busy", 32'(busy), 32'd0);
        // external line select and withdrawal
        ext_irq_n = 4'b1001;
        mtvec = 32'h100;
        step();
        check("ext_id1", 32'(ext_id), 32'd1);
        check("ext_cause", trap_cause, 32'h8000_000B);
        check("ext_vec", trap_vector, VEC ? 32'h12C : 32'h100);
        ext_irq_n = 4'b1111;
        step();
        check("ext_withdraw", 32'(trap_req), 32'd0);
        ti_n = 1'b0;
        step();
        ti_n = 1'b1;
        step();
        check("tmr_withdraw", 32'(trap_req), 32'd0);
        check("tmr_withdraw_save", 32'(csr_save_n), 32'd1);
        // ecall pre-empts a latched timer and is never withdrawn
        ti_n = 1'b0;
        step();
        ecall_n = 1'b0;
        step();
        ecall_n = 1'b1;
        ti_n = 1'b1;
        check("pre_cause", trap_cause, 32'hB);
        check("pre_req", 32'(trap_req), 32'd1);
        step();
        check("exc_held", 32'(trap_req), 32'd1);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        step();
        ecall_n = 1'b0;
        ebreak_n = 1'b0;
        step();
        ecall_n = 1'b1;
        ebreak_n = 1'b1;
        check("dual_once", 32'(drop_cnt), 32'd4);
        repeat (260) begin
            ecall_n = 1'b0;
            step();
            ecall_n = 1'b1;
            step();
        end
        check("drop_sat", 32'(drop_cnt), 32'hFF);
        mret_n = 1'b0;
        step();
        mret_n = 1'b1;
        step();
        // asynchronous reset in SAVE
        ti_n = 1'b0;
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        ti_n = 1'b1;
        check("pre_rst_save", 32'(csr_save_n), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        step();
        rst_n = 1'b1;
        step();
        check("arst_no_rest", 32'(csr_restore_n), 32'd1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ecall_n = $urandom_range(0, 9) != 0;
            ebreak_n = $urandom_range(0, 9) != 0;
            mret_n = $urandom_range(0, 5) != 0;
            trap_ack = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 7) == 0) ti_n = 1'($urandom);
            if ($urandom_range(0, 7) == 0) ext_irq_n = 4'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                mie_bits = 3'($urandom);
                mstatus_mie = 1'($urandom);
            end
            if ($urandom_range(0, 63) == 0) mtvec = $urandom;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
